// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor. Consumes WIDTH-bit operands DIGIT_W bits per
// clock, least-significant digit first, and keeps the ripple carry in a register
// between digits. Valid/ready handshakes are used on both the request side and
// the result side.
module serial_adder #(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int N     = WIDTH / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;

    // Latched operands. They shift right one digit per RUN cycle, so the
    // current digit is always in the low bits.
    logic [WIDTH-1:0]   a_q, b_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    // Assembly register. Each new digit enters at the top and the register
    // shifts right, so after N digits the first digit sits at bit 0.
    logic [WIDTH-1:0]   part_q;

    // Result registers. They are kept apart from part_q so the outputs stay
    // stable in DONE and IDLE while the next sum is being built.
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q, ovf_q, zero_q;

    logic               last_digit;
    logic [DIGIT_W-1:0] digit_a, digit_b;
    logic [DIGIT_W:0]   digit_res;
    logic [WIDTH-1:0]   part_d;
    logic               carry_into_msb;

    assign last_digit = (cnt_q == CNT_W'(N - 1));
    assign digit_a    = a_q[DIGIT_W-1:0];
    assign digit_b    = b_q[DIGIT_W-1:0];
    assign digit_res  = {1'b0, digit_a} + {1'b0, digit_b} + {{DIGIT_W{1'b0}}, carry_q};
    assign part_d     = (part_q >> DIGIT_W)
                      | (WIDTH'(digit_res[DIGIT_W-1:0]) << (WIDTH - DIGIT_W));
    // On the top digit, a ^ b ^ s at the MSB recovers the carry into the MSB.
    assign carry_into_msb = digit_a[DIGIT_W-1] ^ digit_b[DIGIT_W-1] ^ digit_res[DIGIT_W-1];

    // Handshake status is decoded directly from the state. Reset forces IDLE
    // asynchronously, so these outputs reach their reset values at once.
    assign o_ready    = (state_q == S_IDLE);
    assign o_valid    = (state_q == S_DONE);
    assign o_sum      = sum_q;
    assign o_cout     = cout_q;
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential blocks use non-blocking (<=) so that every register
        // samples values from before the edge, whatever order the blocks run in.
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: accept in IDLE, N digit cycles, then hold until the result is taken.
    always_comb begin
        // NOTE: assign the default first so that no path leaves state_d
        // unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_valid)    state_d = S_RUN;
            S_RUN:   if (last_digit) state_d = S_DONE;
            S_DONE:  if (i_ready)    state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, add one digit per RUN cycle, and
    // publish the result on the last digit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: these are ordinary flops, not a memory array, so they are all
            // reset here. That clears any stale operand or result on an abort.
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        // Subtraction is A + ~B + 1: the +1 comes in as the initial carry.
                        a_q     <= i_a;
                        b_q     <= i_sub ? ~i_b : i_b;
                        carry_q <= i_sub | i_cin;
                        cnt_q   <= '0;
                        part_q  <= '0;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> DIGIT_W;
                    b_q     <= b_q >> DIGIT_W;
                    carry_q <= digit_res[DIGIT_W];
                    part_q  <= part_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_digit) begin
                        sum_q  <= part_d;
                        cout_q <= digit_res[DIGIT_W];
                        ovf_q  <= carry_into_msb ^ digit_res[DIGIT_W];
                        zero_q <= (part_d == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder. One 8-bit/2-bit instance covers the
// handshake, backpressure and reset-abort behaviour. Two 16-bit instances
// (N=1 and N=16) share one stimulus stream and are checked for latency and
// arithmetic against a full-width reference.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit, 2-bit digits (N=4)
    logic       v8, rdy8, cin8, sub8;
    logic [7:0] a8, b8;
    logic       ordy8, ov8, cout8, ovf8, zero8;
    logic [7:0] sum8;

    // 16-bit shared stimulus
    logic        v16, rdy16, cin16, sub16;
    logic [15:0] a16, b16;
    logic        ordy_n1, ov_n1, cout_n1, ovf_n1, zero_n1;
    logic [15:0] sum_n1;
    logic        ordy_n16, ov_n16, cout_n16, ovf_n16, zero_n16;
    logic [15:0] sum_n16;

    int tests = 0;
    int fails = 0;

    serial_adder #(.WIDTH(8), .DIGIT_W(2)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(ordy8),
        .i_a(a8), .i_b(b8), .i_cin(cin8), .i_sub(sub8),
        .o_valid(ov8), .i_ready(rdy8), .o_sum(sum8), .o_cout(cout8),
        .o_overflow(ovf8), .o_zero(zero8)
    );

    serial_adder #(.WIDTH(16), .DIGIT_W(16)) dut_n1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(ordy_n1),
        .i_a(a16), .i_b(b16), .i_cin(cin16), .i_sub(sub16),
        .o_valid(ov_n1), .i_ready(rdy16), .o_sum(sum_n1), .o_cout(cout_n1),
        .o_overflow(ovf_n1), .o_zero(zero_n1)
    );

    serial_adder #(.WIDTH(16), .DIGIT_W(1)) dut_n16 (
        .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(ordy_n16),
        .i_a(a16), .i_b(b16), .i_cin(cin16), .i_sub(sub16),
        .o_valid(ov_n16), .i_ready(rdy16), .o_sum(sum_n16), .o_cout(cout_n16),
        .o_overflow(ovf_n16), .o_zero(zero_n16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request to the 8-bit instance (called at posedge+1) and wait for o_valid.
    task automatic req8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [7:0] es, input logic ec, input logic eo, input logic ez);
        int lat;
        chk({tag, " ready_before"}, 32'(ordy8), 32'd1);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        // The latched copies must be used from now on.
        a8 = ~a; b8 = ~b; cin8 = ~cin; sub8 = ~sub;
        chk({tag, " ready_in_run"}, 32'(ordy8), 32'd0);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (ov8 === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " sum"},      32'(sum8),  32'(es));
        chk({tag, " cout"},     32'(cout8), 32'(ec));
        chk({tag, " overflow"}, 32'(ovf8),  32'(eo));
        chk({tag, " zero"},     32'(zero8), 32'(ez));
    endtask

    // Take the pending 8-bit result with a one-cycle i_ready.
    task automatic ack8(input string tag);
        rdy8 = 1'b1;
        @(posedge clk); #1;
        rdy8 = 1'b0;
        chk({tag, " ready_after_ack"}, 32'(ordy8), 32'd1);
        chk({tag, " valid_after_ack"}, 32'(ov8),   32'd0);
    endtask

    // Full-width reference: {cout, overflow, sum}.
    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
        logic [15:0] be;
        logic [16:0] full;
        logic        ovf;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {16'd0, (sub | cin)};
        ovf  = (a[15] == be[15]) && (full[15] != a[15]);
        return {full[16], ovf, full[15:0]};
    endfunction

    // Drive both 16-bit instances with one request and check latency and results.
    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        logic [17:0] exp;
        int          lat1, lat16;
        logic [17:0] got1, got16;
        logic        z1, z16;
        exp = model16(a, b, cin, sub);
        lat1 = 0; lat16 = 0; got1 = '0; got16 = '0; z1 = 1'b0; z16 = 1'b0;
        a16 = a; b16 = b; cin16 = cin; sub16 = sub; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        a16 = ~a; b16 = ~b; sub16 = ~sub;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (lat1 == 0 && ov_n1 === 1'b1) begin
                lat1 = k; got1 = {cout_n1, ovf_n1, sum_n1}; z1 = zero_n1;
            end
            if (lat16 == 0 && ov_n16 === 1'b1) begin
                lat16 = k; got16 = {cout_n16, ovf_n16, sum_n16}; z16 = zero_n16;
            end
        end
        chk({tag, " n1 latency"},  32'(lat1),  32'd1);
        chk({tag, " n1 result"},   32'(got1),  32'(exp));
        chk({tag, " n1 zero"},     32'(z1),    32'(exp[15:0] == 16'd0));
        chk({tag, " n16 latency"}, 32'(lat16), 32'd16);
        chk({tag, " n16 result"},  32'(got16), 32'(exp));
        chk({tag, " n16 zero"},    32'(z16),   32'(exp[15:0] == 16'd0));
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        v8 = 1'b0; rdy8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0;
        v16 = 1'b0; rdy16 = 1'b1; a16 = 16'h0; b16 = 16'h0; cin16 = 1'b0; sub16 = 1'b0;
        #1;
        chk("reset ready",    32'(ordy8), 32'd1);
        chk("reset valid",    32'(ov8),   32'd0);
        chk("reset sum",      32'(sum8),  32'd0);
        chk("reset flags",    32'({cout8, ovf8, zero8}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic add: 0x5A + 0x33 = 0x8D, signed 90 + 51 overflows.
        req8("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b0);
        ack8("add_5a_33");
        // Wrap to zero, then the same operands with carry-in.
        req8("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        ack8("wrap_ff_01");
        req8("wrap_ff_01_cin", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
        ack8("wrap_ff_01_cin");
        // Subtract: borrow (cout=0); cin is ignored.
        req8("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        ack8("sub_10_20");
        // Subtract: -128 - 1 overflows.
        req8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        ack8("sub_80_01");
        req8("sub_33_33", 8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        ack8("sub_33_33");

        // Backpressure: result 0x80 held for 3 cycles while new requests are offered.
        req8("bp_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            v8 = 1'b1; a8 = 8'(c * 37 + 5); b8 = 8'(c * 91 + 3); sub8 = c[0];
            @(posedge clk); #1;
            chk("bp valid_held",  32'(ov8),   32'd1);
            chk("bp ready_low",   32'(ordy8), 32'd0);
            chk("bp sum_held",    32'(sum8),  32'h80);
            chk("bp flags_held",  32'({cout8, ovf8, zero8}), 32'b010);
        end
        v8 = 1'b0;
        ack8("bp");
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ov8 === 1'b1 || ordy8 !== 1'b1) seen++;
        end
        chk("bp no_accept_during_done", 32'(seen), 32'd0);
        chk("bp sum_kept_in_idle", 32'(sum8), 32'h80);

        // Reset between E2 and E3 aborts the request with no o_valid pulse.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; v8 = 1'b1;
        @(posedge clk); #1;       // E0
        v8 = 1'b0;
        @(posedge clk);           // E1
        @(posedge clk);           // E2
        #3;
        rst = 1'b1;
        #1;
        chk("abort ready", 32'(ordy8), 32'd1);
        chk("abort valid", 32'(ov8),   32'd0);
        chk("abort sum",   32'(sum8),  32'd0);
        chk("abort flags", 32'({cout8, ovf8, zero8}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ov8 === 1'b1) seen++;
        end
        chk("abort no_valid", 32'(seen), 32'd0);
        req8("after_abort_01_02", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
        ack8("after_abort");

        // Configuration sweep on 16-bit instances (N=1 and N=16).
        run16("w16 add",      16'h1234, 16'h4321, 1'b0, 1'b0);
        run16("w16 wrap_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run16("w16 ovf_add",  16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run16("w16 borrow",   16'h0005, 16'h0007, 1'b1, 1'b1);
        run16("w16 ovf_sub",  16'h8000, 16'h0001, 1'b0, 1'b1);
        run16("w16 sub_zero", 16'hABCD, 16'hABCD, 1'b0, 1'b1);
        for (int r = 0; r < 30; r++) begin
            run16("w16 rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
